// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared core definitions: widths, ALU/writeback/immediate encodings
package cpu_defs;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  typedef struct packed {
    logic reg_we;
    logic mem_we;
    logic mem_re;
    logic branch;
    logic jump;
  } ctrl_t;
endpackage

// File: rtl/id_ex_reg_hazard_detect.sv
// rtl/id_ex_reg_hazard_detect.sv - combinational load-use compare between EX destination and ID sources
module hazard_detect
  import cpu_defs::*;
(
  input  logic             ex_valid_i,
  input  logic             ex_mem_re_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             id_valid_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  output logic             load_use_o
);
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit    = id_rs1_used_i & (id_rs1_i == ex_rd_i);
  assign rs2_hit    = id_rs2_used_i & (id_rs2_i == ex_rd_i);
  // x0 is never a real destination, so a load to x0 cannot create a dependency
  assign load_use_o = ex_valid_i & ex_mem_re_i & (ex_rd_i != '0) & id_valid_i & (rs1_hit | rs2_hit);
endmodule

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with load-use stall, flush, hold and bubble counter
module id_ex_reg
  import cpu_defs::*;
#(
  parameter int XLEN  = cpu_defs::XLEN,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             id_valid_i,
  input  logic [XLEN-1:0]  id_pc_i,
  input  logic [XLEN-1:0]  id_rs1_data_i,
  input  logic [XLEN-1:0]  id_rs2_data_i,
  input  logic [XLEN-1:0]  id_ext_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [3:0]       id_alu_op_i,
  input  logic [1:0]       id_wb_sel_i,
  input  logic             id_reg_we_i,
  input  logic             id_mem_we_i,
  input  logic             id_mem_re_i,
  input  logic             id_branch_i,
  input  logic             id_jump_i,
  input  logic             flush_i,
  input  logic             hold_i,
  output logic             stall_o,
  output logic             ex_valid_o,
  output logic [XLEN-1:0]  ex_pc_o,
  output logic [XLEN-1:0]  ex_rs1_data_o,
  output logic [XLEN-1:0]  ex_rs2_data_o,
  output logic [XLEN-1:0]  ex_ext_o,
  output logic [REG_W-1:0] ex_rs1_o,
  output logic [REG_W-1:0] ex_rs2_o,
  output logic [REG_W-1:0] ex_rd_o,
  output logic             ex_rs1_used_o,
  output logic             ex_rs2_used_o,
  output logic [3:0]       ex_alu_op_o,
  output logic [1:0]       ex_wb_sel_o,
  output logic             ex_reg_we_o,
  output logic             ex_mem_we_o,
  output logic             ex_mem_re_o,
  output logic             ex_branch_o,
  output logic             ex_jump_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);
  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  ext;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             rs1_used;
    logic             rs2_used;
    logic [3:0]       alu_op;
    logic [1:0]       wb_sel;
    ctrl_t            ctrl;
  } ex_t;

  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;

  hazard_detect u_hazard (
    .ex_valid_i    (ex_q.valid),
    .ex_mem_re_i   (ex_q.ctrl.mem_re),
    .ex_rd_i       (ex_q.rd),
    .id_valid_i    (id_valid_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .load_use_o    (load_use)
  );

  // a flush overrides the stall so IF/ID can accept the redirected fetch
  assign stall_o = !flush_i & (hold_i | load_use);

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      ex_d = '0;
    end else if (hold_i) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = '0;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else begin
      ex_d.valid    = id_valid_i;
      ex_d.pc       = id_pc_i;
      ex_d.rs1_data = id_rs1_data_i;
      ex_d.rs2_data = id_rs2_data_i;
      ex_d.ext      = id_ext_i;
      ex_d.rs1      = id_rs1_i;
      ex_d.rs2      = id_rs2_i;
      ex_d.rd       = id_rd_i;
      ex_d.rs1_used = id_rs1_used_i;
      ex_d.rs2_used = id_rs2_used_i;
      ex_d.alu_op   = id_alu_op_i;
      ex_d.wb_sel   = id_wb_sel_i;
      // an invalid slot must never write architectural state
      ex_d.ctrl     = id_valid_i ? {id_reg_we_i, id_mem_we_i, id_mem_re_i, id_branch_i, id_jump_i} : '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid_o    = ex_q.valid;
  assign ex_pc_o       = ex_q.pc;
  assign ex_rs1_data_o = ex_q.rs1_data;
  assign ex_rs2_data_o = ex_q.rs2_data;
  assign ex_ext_o      = ex_q.ext;
  assign ex_rs1_o      = ex_q.rs1;
  assign ex_rs2_o      = ex_q.rs2;
  assign ex_rd_o       = ex_q.rd;
  assign ex_rs1_used_o = ex_q.rs1_used;
  assign ex_rs2_used_o = ex_q.rs2_used;
  assign ex_alu_op_o   = ex_q.alu_op;
  assign ex_wb_sel_o   = ex_q.wb_sel;
  assign ex_reg_we_o   = ex_q.ctrl.reg_we;
  assign ex_mem_we_o   = ex_q.ctrl.mem_we;
  assign ex_mem_re_o   = ex_q.ctrl.mem_re;
  assign ex_branch_o   = ex_q.ctrl.branch;
  assign ex_jump_o     = ex_q.ctrl.jump;
  assign bubble_cnt_o  = cnt_q;
endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - directed-vector scoreboard bench for id_ex_reg
module tb_id_ex_reg;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] ext;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        u1;
    logic        u2;
    logic [3:0]  alu;
    logic [1:0]  wb;
    logic        reg_we;
    logic        mem_we;
    logic        mem_re;
    logic        branch;
    logic        jump;
  } instr_t;

  typedef struct {
    int id;
    bit fl;
    bit hd;
    bit rs;
    bit st;
    int ex;
    int cnt;
  } row_t;

  typedef struct {
    int     row;
    bit     st;
    instr_t ex;
    int     cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset_i;
  instr_t id;
  logic flush_i, hold_i;

  logic        stall_o, ex_valid_o, ex_rs1_used_o, ex_rs2_used_o;
  logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_ext_o;
  logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [3:0]  ex_alu_op_o;
  logic [1:0]  ex_wb_sel_o;
  logic        ex_reg_we_o, ex_mem_we_o, ex_mem_re_o, ex_branch_o, ex_jump_o;
  logic [15:0] bubble_cnt_o;

  logic        s_stall, s_valid, s_u1, s_u2, s_rwe, s_mwe, s_mre, s_br, s_jp;
  logic [31:0] s_pc, s_r1d, s_r2d, s_ext;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [3:0]  s_alu;
  logic [1:0]  s_wb;
  logic [2:0]  s_cnt;

  instr_t itab [0:10];
  row_t   rows [$];
  exp_t   sb [$];
  int     total = 0;
  int     bad = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.XLEN(32), .CNT_W(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .id_valid_i(id.valid), .id_pc_i(id.pc),
    .id_rs1_data_i(id.rs1d), .id_rs2_data_i(id.rs2d), .id_ext_i(id.ext),
    .id_rs1_i(id.rs1), .id_rs2_i(id.rs2), .id_rd_i(id.rd),
    .id_rs1_used_i(id.u1), .id_rs2_used_i(id.u2), .id_alu_op_i(id.alu), .id_wb_sel_i(id.wb),
    .id_reg_we_i(id.reg_we), .id_mem_we_i(id.mem_we), .id_mem_re_i(id.mem_re),
    .id_branch_i(id.branch), .id_jump_i(id.jump), .flush_i(flush_i), .hold_i(hold_i),
    .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o), .ex_ext_o(ex_ext_o),
    .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
    .ex_rs1_used_o(ex_rs1_used_o), .ex_rs2_used_o(ex_rs2_used_o),
    .ex_alu_op_o(ex_alu_op_o), .ex_wb_sel_o(ex_wb_sel_o), .ex_reg_we_o(ex_reg_we_o),
    .ex_mem_we_o(ex_mem_we_o), .ex_mem_re_o(ex_mem_re_o), .ex_branch_o(ex_branch_o),
    .ex_jump_o(ex_jump_o), .bubble_cnt_o(bubble_cnt_o)
  );

  // narrow-counter copy fed the same stimulus, to reach saturation in a few cycles
  id_ex_reg #(.XLEN(32), .CNT_W(3)) dut_sat (
    .clk_i(clk), .reset_i(reset_i), .id_valid_i(id.valid), .id_pc_i(id.pc),
    .id_rs1_data_i(id.rs1d), .id_rs2_data_i(id.rs2d), .id_ext_i(id.ext),
    .id_rs1_i(id.rs1), .id_rs2_i(id.rs2), .id_rd_i(id.rd),
    .id_rs1_used_i(id.u1), .id_rs2_used_i(id.u2), .id_alu_op_i(id.alu), .id_wb_sel_i(id.wb),
    .id_reg_we_i(id.reg_we), .id_mem_we_i(id.mem_we), .id_mem_re_i(id.mem_re),
    .id_branch_i(id.branch), .id_jump_i(id.jump), .flush_i(flush_i), .hold_i(hold_i),
    .stall_o(s_stall), .ex_valid_o(s_valid), .ex_pc_o(s_pc),
    .ex_rs1_data_o(s_r1d), .ex_rs2_data_o(s_r2d), .ex_ext_o(s_ext),
    .ex_rs1_o(s_rs1), .ex_rs2_o(s_rs2), .ex_rd_o(s_rd),
    .ex_rs1_used_o(s_u1), .ex_rs2_used_o(s_u2),
    .ex_alu_op_o(s_alu), .ex_wb_sel_o(s_wb), .ex_reg_we_o(s_rwe),
    .ex_mem_we_o(s_mwe), .ex_mem_re_o(s_mre), .ex_branch_o(s_br),
    .ex_jump_o(s_jp), .bubble_cnt_o(s_cnt)
  );

  function automatic instr_t exp_of(int k);
    instr_t e;
    if (k < 0) return '0;
    e = itab[k];
    if (!e.valid) begin
      e.reg_we = 1'b0; e.mem_we = 1'b0; e.mem_re = 1'b0; e.branch = 1'b0; e.jump = 1'b0;
    end
    return e;
  endfunction

  task automatic add_row(input int i, input bit fl, input bit hd, input bit rs,
                         input bit st, input int ex, input int cnt);
    row_t r;
    r.id = i; r.fl = fl; r.hd = hd; r.rs = rs; r.st = st; r.ex = ex; r.cnt = cnt;
    rows.push_back(r);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t   e;
      instr_t act;
      int     sat;
      e = sb.pop_front();
      act = '{ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_ext_o, ex_rs1_o, ex_rs2_o,
              ex_rd_o, ex_rs1_used_o, ex_rs2_used_o, ex_alu_op_o, ex_wb_sel_o, ex_reg_we_o,
              ex_mem_we_o, ex_mem_re_o, ex_branch_o, ex_jump_o};
      sat = (e.cnt > 7) ? 7 : e.cnt;
      total += 4;
      if (act !== e.ex) begin
        bad++;
        $display("FAIL ex_bundle row %0d: got %h want %h", e.row, act, e.ex);
      end
      if (stall_o !== e.st) begin
        bad++;
        $display("FAIL stall row %0d: got %b want %b", e.row, stall_o, e.st);
      end
      if (bubble_cnt_o !== 16'(e.cnt)) begin
        bad++;
        $display("FAIL bubble_cnt row %0d: got %0d want %0d", e.row, bubble_cnt_o, e.cnt);
      end
      if (s_cnt !== 3'(sat)) begin
        bad++;
        $display("FAIL sat_cnt row %0d: got %0d want %0d", e.row, s_cnt, sat);
      end
    end
  end

  initial begin
    itab[0]  = '0;
    itab[1]  = '{1'b1, 32'h0,  32'h11,   32'h22, 32'hFFFFFFF0, 5'd1,  5'd2, 5'd3, 1'b1, 1'b1, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    itab[2]  = '{1'b1, 32'h4,  32'h33,   32'h22, 32'hFFFFFFF0, 5'd3,  5'd2, 5'd4, 1'b1, 1'b1, 4'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    itab[3]  = '{1'b1, 32'h8,  32'h44,   32'h11, 32'hFFFFFFF0, 5'd4,  5'd1, 5'd7, 1'b1, 1'b1, 4'd8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    itab[4]  = '{1'b1, 32'hC,  32'h1000, 32'h0,  32'h0,        5'd10, 5'd0, 5'd5, 1'b1, 1'b0, 4'd0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    itab[5]  = '{1'b1, 32'h10, 32'h0,    32'h11, 32'h0,        5'd5,  5'd1, 5'd6, 1'b1, 1'b1, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    itab[6]  = '{1'b1, 32'h14, 32'h1000, 32'h0,  32'h4,        5'd10, 5'd0, 5'd0, 1'b1, 1'b0, 4'd0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    itab[7]  = '{1'b1, 32'h18, 32'h0,    32'h0,  32'h0,        5'd0,  5'd0, 5'd8, 1'b1, 1'b1, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    itab[8]  = '{1'b1, 32'h1C, 32'h11,   32'h55, 32'h5,        5'd1,  5'd5, 5'd9, 1'b1, 1'b0, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    itab[9]  = '{1'b0, 32'h20, 32'hAA,   32'hBB, 32'hCC,       5'd1,  5'd2, 5'd3, 1'b1, 1'b1, 4'd2, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    itab[10] = '{1'b1, 32'h40, 32'h2000, 32'h0,  32'h8,        5'd5,  5'd0, 5'd5, 1'b1, 1'b0, 4'd0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // id, flush, hold, reset, expected stall, expected EX contents (-1 = bubble), expected count
    add_row(1, 0, 0, 0, 0, -1, 0);
    add_row(2, 0, 0, 0, 0,  1, 0);
    add_row(3, 0, 0, 0, 0,  2, 0);
    add_row(4, 0, 0, 0, 0,  3, 0);
    add_row(5, 0, 0, 0, 1,  4, 0);
    add_row(5, 0, 0, 0, 0, -1, 1);
    add_row(6, 0, 0, 0, 0,  5, 1);
    add_row(7, 0, 0, 0, 0,  6, 1);
    add_row(4, 0, 0, 0, 0,  7, 1);
    add_row(8, 0, 0, 0, 0,  4, 1);
    add_row(9, 0, 0, 0, 0,  8, 1);
    add_row(4, 0, 0, 0, 0,  9, 1);
    add_row(5, 1, 0, 0, 0,  4, 1);
    add_row(1, 0, 0, 0, 0, -1, 1);
    add_row(4, 0, 0, 0, 0,  1, 1);
    add_row(5, 0, 1, 0, 1,  4, 1);
    add_row(5, 0, 1, 0, 1,  4, 1);
    add_row(5, 0, 1, 0, 1,  4, 1);
    add_row(5, 0, 0, 0, 1,  4, 1);
    add_row(5, 0, 0, 0, 0, -1, 2);
    add_row(0, 0, 0, 0, 0,  5, 2);
    for (int i = 0; i < 7; i++) begin
      add_row(10, 0, 0, 0, 0, -1, 2 + i);
      add_row(10, 0, 0, 0, 1, 10, 2 + i);
    end
    add_row(10, 0, 0, 0, 0, -1, 9);
    add_row(10, 0, 0, 1, 0, -1, 0);
    add_row(1,  0, 0, 0, 0, -1, 0);
    add_row(0,  0, 0, 0, 0,  1, 0);

    reset_i = 1'b1;
    id = '0;
    flush_i = 1'b0;
    hold_i = 1'b0;
    repeat (3) @(posedge clk);
    for (int n = 0; n < rows.size(); n++) begin
      exp_t e;
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      id = itab[rows[n].id];
      flush_i = rows[n].fl;
      hold_i = rows[n].hd;
      e.row = n;
      e.st = rows[n].st;
      e.ex = exp_of(rows[n].ex);
      e.cnt = rows[n].cnt;
      sb.push_back(e);
      if (rows[n].rs) begin
        #2;
        reset_i = 1'b1;
      end
    end
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register for the five-stage core: it captures the decoded ID-stage bundle (register operands, the sign-extended immediate from the immediate generator, destination and control bits) and presents it to EX one cycle later. It contains load-use hazard detection, which drives the stall to PC/IF-ID and inserts a bubble. It also applies branch-redirect flushes and downstream hold, and counts inserted bubbles for performance monitoring.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `CNT_W`, 16, width of the bubble counter.

Ports:
- `clk_i` in 1: core clock; all state updates on the rising edge.
- `reset_i` in 1: asynchronous reset, active-high.
- `id_valid_i` in 1: ID holds a real instruction.
- `id_pc_i` in XLEN: PC of the ID instruction.
- `id_rs1_data_i` / `id_rs2_data_i` in XLEN: register-file read data.
- `id_ext_i` in XLEN: sign-extended immediate.
- `id_rs1_i` / `id_rs2_i` / `id_rd_i` in 5: register indices.
- `id_rs1_used_i` / `id_rs2_used_i` in 1: the source is actually read.
- `id_alu_op_i` in 4, `id_wb_sel_i` in 2: ALU op and writeback select.
- `id_reg_we_i`, `id_mem_we_i`, `id_mem_re_i`, `id_branch_i`, `id_jump_i` in 1 each: control bits.
- `flush_i` in 1: EX resolved a taken branch or jump; kill ID.
- `hold_i` in 1: downstream cannot accept; freeze.
- `stall_o` out 1: freeze PC and IF/ID this cycle.
- `ex_*_o` out: registered copies of every `id_*_i` above, same widths, with `id_` replaced by `ex_` (including `ex_valid_o`).
- `bubble_cnt_o` out CNT_W: saturating count of inserted bubbles.

## Operation
Hazard detection (combinational): `load_use` = `ex_valid_o & ex_mem_re_o & (ex_rd_o != 0) & id_valid_i & ((id_rs1_used_i & id_rs1_i==ex_rd_o) | (id_rs2_used_i & id_rs2_i==ex_rd_o))`.

`stall_o` = `!flush_i & (hold_i | load_use)`.

Register update, by priority per cycle:
1. `reset_i`: bubble, counter cleared.
2. `flush_i`: load a bubble, regardless of hold or load_use.
3. `hold_i`: all `ex_*` outputs keep their value; the counter is unchanged.
4. `load_use`: load a bubble; the counter increments.
5. Otherwise: load the `id_*` bundle, `ex_valid_o` = `id_valid_i`.

Bubble definition:
- `ex_valid_o`, `ex_reg_we_o`, `ex_mem_we_o`, `ex_mem_re_o`, `ex_branch_o` and `ex_jump_o` are 0.
- All data and index fields are 0.
- `ex_alu_op_o` and `ex_wb_sel_o` are 0.

Loading rules:
- When `id_valid_i` = 0 in case 5, control bits are loaded as zero, so an invalid slot never writes state.
- `bubble_cnt_o` saturates at all-ones and never wraps.
- A flush is not counted as a bubble.

## Timing
- Reset values: every `ex_*_o` and `bubble_cnt_o` are 0; `stall_o` is 0 while reset is held with no load in EX.
- Latency: one cycle from ID inputs to `ex_*` outputs.
- `stall_o` is combinational from the current `ex_*` state and the `id_*` and control inputs, valid in the same cycle. IF/ID and PC must sample it before the edge.
- Load-use costs exactly one bubble. On the next cycle EX holds the bubble, `load_use` deasserts, and the ID instruction, still present because of the stall, loads normally.
- Hold with a pending load_use: the register freezes (the load stays in EX) and `stall_o` stays 1. When hold releases, the bubble is inserted that cycle.
- Flush with load_use in the same cycle: bubble, `stall_o` = 0, so IF/ID accepts the redirected fetch. No count.
- An asynchronous reset asserted mid-stall clears state immediately; `stall_o` drops once `ex_valid_o` is 0.

## Structure
- The shared package `cpu_defs` holds:
  - ALU op codes and wb_sel encodings.
  - Immediate-select encodings.
  - The register-index width (5) and `XLEN`.
- Sub-module `hazard_detect`: purely combinational `load_use` compare. It is reused later for forwarding-unit checks.
- The register and counter live in `id_ex_reg`.

## Test plan
- Normal flow: three ALU instructions back to back, pc 0x0/0x4/0x8, `id_ext_i`=0xFFFFFFF0 → each appears on `ex_*` one cycle later, `stall_o`=0, `bubble_cnt_o`=0.
- Load-use: lw x5 in EX, ID add x6,x5,x1 with rs1_used → `stall_o`=1 for one cycle, then `ex_valid_o`=0, `bubble_cnt_o`=1. The next cycle the add is loaded.
- No false hazard cases, each giving `stall_o`=0:
  - lw x0 in EX with ID reading x0.
  - ID rs2=x5 with `id_rs2_used_i`=0.
- Flush plus load_use in the same cycle → bubble loaded, `stall_o`=0, counter unchanged.
- Hold for 3 cycles with a load in EX and a dependent instruction in ID → `ex_*` outputs stable and `stall_o`=1 throughout. After release: one bubble, counter +1.
- Reset: assert `reset_i` asynchronously mid-cycle during a stall → outputs go to 0 immediately, before the next edge. Also preload the counter to 0xFFFF and force a load_use → counter stays 0xFFFF.
